// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for the memory stream reader: default widths, FSM states
// and the count-saturation helper.
package mem_stream_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // A request longer than the memory depth would revisit addresses, so clamp it.
    function automatic int unsigned sat_count(input int unsigned cnt, input int unsigned addr_w);
        int unsigned depth;
        depth = 32'd1 << addr_w;
        return (cnt > depth) ? depth : cnt;
    endfunction

endpackage

// File: rtl/mem_stream_reader_if.sv
// Memory read port plus valid/ready output stream seen by the reader.
// master = the reader, slave = the memory/consumer side.
interface mem_stream_reader_if #(
    parameter int ADDR_W = mem_stream_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_stream_pkg::DATA_W_DEF
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_addr,
        input  mem_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/mem_stream_reader.sv
// Walks count consecutive addresses (mod depth) from base through a combinational
// memory and emits each registered word on a backpressured valid/ready stream.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    mem_stream_reader_if.master bus
);

    localparam int CNT_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  eff_count;
    logic              load;
    logic              handshake;

    assign eff_count = CNT_W'(sat_count(32'(count), ADDR_W));
    assign handshake = out_valid_q & bus.out_ready;
    // The output register may refill whenever it is empty or being drained this cycle.
    assign load      = (state_q == ST_READ) & (~out_valid_q | bus.out_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && (eff_count != '0)) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (load && (remaining_q == CNT_W'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (handshake) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        if (handshake && !load) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                // A zero-length command completes immediately without touching the stream.
                if (start) begin
                    mem_addr_d  = base;
                    remaining_d = eff_count;
                    done_d      = (eff_count == '0);
                end
            end
            ST_READ: begin
                if (load) begin
                    out_data_d  = bus.mem_data;
                    out_valid_d = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (handshake) begin
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy          = (state_q != ST_IDLE);
        done          = done_q;
        bus.mem_addr  = mem_addr_q;
        bus.out_data  = out_data_q;
        bus.out_valid = out_valid_q;
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader against a memory holding word[a] = 10*a.
module tb_mem_stream_reader;
    import mem_stream_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] base;
    logic [4:0] count;
    logic       busy;
    logic       done;

    mem_stream_reader_if bus ();

    mem_stream_reader dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .base  (base),
        .count (count),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign bus.mem_data = 8'(10 * int'(bus.mem_addr));

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got[$];
    logic [7:0] stall_data[$];
    int         valid_cycles;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [3:0] b, input logic [4:0] c);
        start = 1'b1;
        base  = b;
        count = c;
        tick();
        start = 1'b0;
    endtask

    // Runs the consumer until done (or budget). Stalls the first stall_n valid cycles;
    // at cycle poke_at it raises a stray start with base=9,count=3.
    task automatic collect(input int stall_n, input int poke_at, input int max_cyc,
                           output int done_at);
        int n;
        int stalls;
        n = 0;
        stalls = stall_n;
        done_at = -1;
        got.delete();
        stall_data.delete();
        valid_cycles = 0;
        while (n < max_cyc && done_at < 0) begin
            if (n == poke_at) begin
                start = 1'b1;
                base  = 4'd9;
                count = 5'd3;
            end else begin
                start = 1'b0;
            end
            if (bus.out_valid && stalls > 0) begin
                bus.out_ready = 1'b0;
                stalls--;
                stall_data.push_back(bus.out_data);
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid) valid_cycles++;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            tick();
            n++;
            if (done) done_at = n;
        end
        start = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        base  = '0;
        count = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, bus.out_valid} !== 3'b000)
            begin errors++; $display("FAIL reset_ctrl got busy/done/valid=%b exp 000", {busy, done, bus.out_valid}); end
        checks++;
        if (bus.mem_addr !== 4'd0)
            begin errors++; $display("FAIL reset_addr got %0d exp 0", bus.mem_addr); end
        checks++;
        if (bus.out_data !== 8'd0)
            begin errors++; $display("FAIL reset_data got %0d exp 0", bus.out_data); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_w[3] = '{8'd20, 8'd30, 8'd40};
        int da;
        issue(4'd2, 5'd3);
        checks++;
        if (bus.mem_addr !== 4'd2 || bus.out_valid !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL basic_after_e0 got addr=%0d valid=%b busy=%b exp 2/0/1", bus.mem_addr, bus.out_valid, busy); end
        collect(0, -1, 30, da);
        checks++;
        if (got.size() != 3)
            begin errors++; $display("FAIL basic_len got %0d exp 3", got.size()); end
        else
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== exp_w[i])
                    begin errors++; $display("FAIL basic_word%0d got %0d exp %0d", i, got[i], exp_w[i]); end
            end
        checks++;
        if (da != 4)
            begin errors++; $display("FAIL basic_done_edge got %0d exp 4", da); end
        checks++;
        if (valid_cycles != 3)
            begin errors++; $display("FAIL basic_valid_cycles got %0d exp 3", valid_cycles); end
        checks++;
        if (bus.mem_addr !== 4'd5 || busy !== 1'b0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL basic_end got addr=%0d busy=%b valid=%b exp 5/0/0", bus.mem_addr, busy, bus.out_valid); end
        tick();
        checks++;
        if (done !== 1'b0 || bus.mem_addr !== 4'd5)
            begin errors++; $display("FAIL basic_done_pulse got done=%b addr=%0d exp 0/5", done, bus.mem_addr); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_w[4] = '{8'd140, 8'd150, 8'd0, 8'd10};
        int da;
        issue(4'd14, 5'd4);
        collect(0, -1, 30, da);
        checks++;
        if (got.size() != 4)
            begin errors++; $display("FAIL wrap_len got %0d exp 4", got.size()); end
        else
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_w[i])
                    begin errors++; $display("FAIL wrap_word%0d got %0d exp %0d", i, got[i], exp_w[i]); end
            end
        checks++;
        if (da != 5 || bus.mem_addr !== 4'd2)
            begin errors++; $display("FAIL wrap_end got done_edge=%0d addr=%0d exp 5/2", da, bus.mem_addr); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_w[4] = '{8'd0, 8'd10, 8'd20, 8'd30};
        int da;
        issue(4'd0, 5'd4);
        collect(3, -1, 40, da);
        checks++;
        if (stall_data.size() != 3)
            begin errors++; $display("FAIL bp_stall_len got %0d exp 3", stall_data.size()); end
        else
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (stall_data[i] !== 8'd0)
                    begin errors++; $display("FAIL bp_hold%0d got %0d exp 0", i, stall_data[i]); end
            end
        checks++;
        if (got.size() != 4)
            begin errors++; $display("FAIL bp_len got %0d exp 4", got.size()); end
        else
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_w[i])
                    begin errors++; $display("FAIL bp_word%0d got %0d exp %0d", i, got[i], exp_w[i]); end
            end
        checks++;
        if (da != 8 || valid_cycles != 7)
            begin errors++; $display("FAIL bp_timing got done_edge=%0d valid_cycles=%0d exp 8/7", da, valid_cycles); end
        tick();
    endtask

    task automatic test_zero_count();
        issue(4'd7, 5'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL zero_done got done=%b busy=%b valid=%b exp 1/0/0", done, busy, bus.out_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL zero_quiet%0d got done=%b valid=%b busy=%b exp 0/0/0", i, done, bus.out_valid, busy); end
        end
    endtask

    task automatic test_saturated();
        int da;
        issue(4'd5, 5'd20);
        collect(0, -1, 60, da);
        checks++;
        if (got.size() != 16)
            begin errors++; $display("FAIL sat_len got %0d exp 16", got.size()); end
        else
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got[i] !== 8'(10 * ((5 + i) % 16)))
                    begin errors++; $display("FAIL sat_word%0d got %0d exp %0d", i, got[i], 10 * ((5 + i) % 16)); end
            end
        checks++;
        if (da != 17 || bus.mem_addr !== 4'd5)
            begin errors++; $display("FAIL sat_end got done_edge=%0d addr=%0d exp 17/5", da, bus.mem_addr); end
        tick();
    endtask

    task automatic test_ignored_start();
        logic [7:0] exp_w[5] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
        int da;
        issue(4'd1, 5'd5);
        collect(0, 2, 40, da);
        checks++;
        if (got.size() != 5)
            begin errors++; $display("FAIL ign_len got %0d exp 5", got.size()); end
        else
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== exp_w[i])
                    begin errors++; $display("FAIL ign_word%0d got %0d exp %0d", i, got[i], exp_w[i]); end
            end
        checks++;
        if (da != 6 || bus.mem_addr !== 4'd6)
            begin errors++; $display("FAIL ign_end got done_edge=%0d addr=%0d exp 6/6", da, bus.mem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL ign_quiet%0d got valid=%b busy=%b exp 0/0", i, bus.out_valid, busy); end
        end
    endtask

    task automatic test_reset_mid();
        issue(4'd3, 5'd8);
        bus.out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd40)
            begin errors++; $display("FAIL rst_mid_pre got valid=%b data=%0d exp 1/40", bus.out_valid, bus.out_data); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.out_valid, busy, done} !== 3'b000 || bus.mem_addr !== 4'd0 || bus.out_data !== 8'd0)
            begin errors++; $display("FAIL rst_mid got valid/busy/done=%b addr=%0d data=%0d exp 000/0/0", {bus.out_valid, busy, done}, bus.mem_addr, bus.out_data); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || bus.out_valid !== 1'b0)
                begin errors++; $display("FAIL rst_mid_quiet%0d got done=%b valid=%b exp 0/0", i, done, bus.out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_a[2] = '{8'd20, 8'd30};
        logic [7:0] exp_b[2] = '{8'd80, 8'd90};
        int da;
        issue(4'd2, 5'd2);
        collect(0, -1, 30, da);
        checks++;
        if (da != 3 || got.size() != 2 || got[0] !== exp_a[0] || got[1] !== exp_a[1])
            begin errors++; $display("FAIL b2b_first got done_edge=%0d n=%0d exp 3/2 words 20,30", da, got.size()); end
        start = 1'b1;
        base  = 4'd8;
        count = 5'd2;
        tick();
        start = 1'b0;
        checks++;
        if (bus.mem_addr !== 4'd8 || busy !== 1'b1 || bus.out_valid !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL b2b_start got addr=%0d busy=%b valid=%b done=%b exp 8/1/0/0", bus.mem_addr, busy, bus.out_valid, done); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd80)
            begin errors++; $display("FAIL b2b_first_word got valid=%b data=%0d exp 1/80", bus.out_valid, bus.out_data); end
        collect(0, -1, 30, da);
        checks++;
        if (da != 2 || got.size() != 2 || got[0] !== exp_b[0] || got[1] !== exp_b[1])
            begin errors++; $display("FAIL b2b_second got done_edge=%0d n=%0d exp 2/2 words 80,90", da, got.size()); end
        checks++;
        if (bus.mem_addr !== 4'd10)
            begin errors++; $display("FAIL b2b_addr got %0d exp 10", bus.mem_addr); end
        tick();
    endtask

    initial begin
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_saturated();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
